rocketcpu_wb_dma: RTL and testbench
===================================

Name: rocketcpu_wb_dma

Overview:
- Wishbone bus master (initiator) that copies a block of 32-bit words from one memory-mapped address to another.
- Typical use: flash to RAM, or RAM to the audio parameter registers at 0x1000_0000.
- Configured by the CPU through a small Wishbone slave port.
- Its master port is a second initiator into the data/instruction bus arbiter, alongside the SERV core.

Parameters:
- LEN_W, 16: width of the word-count register and the remaining-word counter.
- SLV_BASE, 32'h0600_0000: base address of the config slave; only bits [3:2] are decoded inside the block.

Ports:
- i_wb_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_wb_adr  in  32  config slave address; bits [3:2] select the register.
- i_wb_dat  in  32  config slave write data.
- i_wb_we  in  1  config slave write enable.
- i_wb_cyc  in  1  config slave cycle (already address-qualified by the top level).
- o_wb_rdt  out  32  config slave read data.
- o_wb_ack  out  1  config slave acknowledge.
- o_wbm_adr  out  32  master address.
- o_wbm_dat  out  32  master write data.
- o_wbm_sel  out  4  master byte select.
- o_wbm_we  out  1  master write enable.
- o_wbm_cyc  out  1  master cycle.
- i_wbm_rdt  in  32  master read data.
- i_wbm_ack  in  1  master acknowledge.
- o_irq  out  1  transfer-complete interrupt (level).

Behaviour:
- Reset (async, active-high):
  - All registers 0, FSM in IDLE.
  - Outputs all 0: o_wb_ack, o_wb_rdt, o_wbm_cyc, o_wbm_we, o_wbm_adr, o_wbm_dat, o_wbm_sel, o_irq.
  - Reset mid-transfer drops o_wbm_cyc immediately (asynchronously). No done flag is set.
- Slave registers:
  - 0x0 SRC: word address; bits [1:0] forced to 0.
  - 0x4 DST: word address; bits [1:0] forced to 0.
  - 0x8 LEN: word count.
  - 0xC CTRL/STATUS:
    - Write: bit0 start, bit1 irq_en, bit2 write-1-to-clear done.
    - Read: bit0 busy, bit1 irq_en, bit2 done, [31:16] remaining count, zero-extended.
- Slave handshake:
  - o_wb_ack pulses high for one cycle, in the cycle after i_wb_cyc is first seen with o_wb_ack low. Back-to-back accesses therefore ack every other cycle.
  - o_wb_rdt is valid together with ack.
- Writes while busy:
  - Writes to SRC, DST or LEN are acked and ignored.
  - A start while busy is ignored.
  - irq_en and done-clear remain writable at all times.
- Start:
  - LEN=0: done is set on the next cycle and no bus cycles are issued.
  - Otherwise: load the working counters from SRC/DST/LEN and enter RD.
- FSM states: IDLE, RD, WR, GAP.
  - RD: cyc=1, we=0, adr=src. On i_wbm_ack, latch i_wbm_rdt into buf and go to WR.
  - WR: cyc=1, we=1, sel=4'b1111, adr=dst, dat=buf. On i_wbm_ack:
    - src+=4, dst+=4, rem-=1.
    - If rem was 1: go to IDLE, set done.
    - Otherwise go to GAP.
  - GAP: cyc=0 for exactly one cycle so the arbiter can grant the CPU, then go to RD.
  - cyc is also low for one cycle between RD and WR. It is deasserted on the ack cycle and reasserted the next cycle.
- Master bus outputs are registered and held stable while cyc is high waiting for ack. There is no timeout; the block waits indefinitely for ack.
- Address arithmetic is modulo 2^32. Wrap past 0xFFFF_FFFC continues at 0 without error.
- o_irq = done & irq_en. If done-clear and completion happen in the same cycle, completion wins and done stays 1.
- busy = (state != IDLE).

Optional Feature:
- Macro: ROCKETCPU_DMA_FILL_EN.
- Defined:
  - CTRL bit3 is fill mode, sampled at start.
  - In fill mode RD is skipped; buf is loaded from the SRC register value. The block writes that constant LEN times to DST, DST+4, ...
  - GAP is still present between writes.
- Undefined: bit3 reads 0, writes to it are ignored, and there is no fill logic.

Decomposition:
- Package rocketcpu_dma_pkg holds:
  - register offsets (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3);
  - CTRL bit indices (CTRL_START, CTRL_IRQEN, CTRL_DONE, CTRL_FILL);
  - the state encoding enum (IDLE, RD, WR, GAP).
- One sub-module is natural: rocketcpu_dma_regs. It holds the slave register file, ack generation and done/irq flag logic, and exports a start pulse plus the config values to the FSM.

Test Plan:
- Copy 4 words:
  - Stimulus: SRC=0x0010_0000, DST=0x0000_0100, LEN=4, start; slave model acks 2 cycles after cyc.
  - Response: RAM 0x100..0x10C equals flash words 0..3; 8 master cycles, alternating we=0/1, cyc low ≥1 cycle between each; then done=1 and busy=0.
- IRQ handling:
  - Stimulus: irq_en=1, LEN=1, start.
  - Response: o_irq rises on completion; writing CTRL=0x6 clears it; with irq_en=0 and the same transfer, o_irq stays 0 while done=1.
- Zero length:
  - Stimulus: LEN=0, start.
  - Response: o_wbm_cyc never asserts; done=1 one cycle after the start ack.
- Busy lockout:
  - Stimulus: during a LEN=3 transfer, write DST=0xDEAD_0000 and start again.
  - Response: transfer completes to the original DST; STATUS[31:16] reads 2, then 1, then 0 as words complete.
- Reset mid-write:
  - Stimulus: assert reset while in WR with ack withheld.
  - Response: o_wbm_cyc falls in the same cycle; all registers read 0 after reset; done=0.
- Fill mode (with ROCKETCPU_DMA_FILL_EN defined):
  - Stimulus: SRC=0x1234_5678, DST=0x1000_0000, LEN=15, fill=1.
  - Response: 15 writes of 0x1234_5678 and zero reads.

Source files
------------

// File: rtl/rocketcpu_dma_pkg.sv
// ============================================================================
// Module   : rocketcpu_dma_pkg
// Purpose  : Shared constants and state encoding for the Wishbone block-copy DMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rocketcpu_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_FILL  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } dma_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rocketcpu_dma_regs.sv
// ============================================================================
// Module   : rocketcpu_dma_regs
// Purpose  : Config slave register file, ack generation and done/irq flags.
//            Fill-mode bit present only with ROCKETCPU_DMA_FILL_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rocketcpu_dma_regs
  import rocketcpu_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_wb_clk,
  input  logic             reset,
  input  logic [1:0]       i_wb_reg,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic             i_busy,
  input  logic [LEN_W-1:0] i_rem,
  input  logic             i_complete,
  output logic             o_start,
  output logic [31:0]      o_src,
  output logic [31:0]      o_dst,
  output logic [LEN_W-1:0] o_len,
`ifdef ROCKETCPU_DMA_FILL_EN
  output logic             o_fill,
`endif
  output logic             o_irq
);

  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic             r_irq_en;
  logic             r_done;
  logic             r_start;
  logic             r_ack;
  logic [31:0]      r_rdt;
`ifdef ROCKETCPU_DMA_FILL_EN
  logic             r_fill;
`endif

  logic        w_access;
  logic        w_wr;
  logic        w_cfg_wr;
  logic        w_ctrl_wr;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  // A new access is taken only while ack is low, giving one ack per two cycles.
  assign w_access  = i_wb_cyc & ~r_ack;
  assign w_wr      = w_access & i_wb_we;
  assign w_cfg_wr  = w_wr & ~i_busy;
  assign w_ctrl_wr = w_wr & (i_wb_reg == REG_CTRL);

  always_comb begin
    w_status             = '0;
    w_status[CTRL_START] = i_busy;
    w_status[CTRL_IRQEN] = r_irq_en;
    w_status[CTRL_DONE]  = r_done;
`ifdef ROCKETCPU_DMA_FILL_EN
    w_status[CTRL_FILL]  = r_fill;
`endif
    w_status[31:16]      = 16'(i_rem);
  end

  always_comb begin
    w_rd_data = '0;
    case (i_wb_reg)
      REG_SRC:  w_rd_data = r_src;
      REG_DST:  w_rd_data = r_dst;
      REG_LEN:  w_rd_data = 32'(r_len);
      REG_CTRL: w_rd_data = w_status;
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_wb_clk or posedge reset) begin
    if (reset) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_start  <= 1'b0;
      r_ack    <= 1'b0;
      r_rdt    <= '0;
`ifdef ROCKETCPU_DMA_FILL_EN
      r_fill   <= 1'b0;
`endif
    end else begin
      r_ack   <= w_access;
      r_start <= 1'b0;
      if (w_access) begin
        r_rdt <= w_rd_data;
      end
      if (w_cfg_wr) begin
        case (i_wb_reg)
          REG_SRC:  r_src <= word_align(i_wb_dat);
          REG_DST:  r_dst <= word_align(i_wb_dat);
          REG_LEN:  r_len <= i_wb_dat[LEN_W-1:0];
          REG_CTRL: begin
            r_start <= i_wb_dat[CTRL_START];
`ifdef ROCKETCPU_DMA_FILL_EN
            r_fill  <= i_wb_dat[CTRL_FILL];
`endif
          end
          default: ;
        endcase
      end
      if (w_ctrl_wr) begin
        r_irq_en <= i_wb_dat[CTRL_IRQEN];
      end
      // Completion has priority over a same-cycle write-1-to-clear.
      if (i_complete || (r_start && (r_len == '0))) begin
        r_done <= 1'b1;
      end else if (w_ctrl_wr && i_wb_dat[CTRL_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

  assign o_wb_rdt = r_rdt;
  assign o_wb_ack = r_ack;
  assign o_start  = r_start;
  assign o_src    = r_src;
  assign o_dst    = r_dst;
  assign o_len    = r_len;
`ifdef ROCKETCPU_DMA_FILL_EN
  assign o_fill   = r_fill;
`endif
  assign o_irq    = r_done & r_irq_en;

endmodule

`default_nettype wire

// File: rtl/rocketcpu_wb_dma.sv
// ============================================================================
// Module   : rocketcpu_wb_dma
// Purpose  : Wishbone master that copies LEN words from SRC to DST, one bus
//            cycle at a time. Define ROCKETCPU_DMA_FILL_EN for constant fill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rocketcpu_wb_dma
  import rocketcpu_dma_pkg::*;
#(
  parameter int          LEN_W    = 16,
  parameter logic [31:0] SLV_BASE = 32'h0600_0000
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_wbm_adr,
  output logic [31:0] o_wbm_dat,
  output logic [3:0]  o_wbm_sel,
  output logic        o_wbm_we,
  output logic        o_wbm_cyc,
  input  logic [31:0] i_wbm_rdt,
  input  logic        i_wbm_ack,
  output logic        o_irq
);

  logic             w_start;
  logic [31:0]      w_cfg_src;
  logic [31:0]      w_cfg_dst;
  logic [LEN_W-1:0] w_cfg_len;
  logic             w_busy;
  logic             w_complete;
  logic             w_unused_adr;

  dma_state_t       r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_rem;
  logic             r_cyc;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
`ifdef ROCKETCPU_DMA_FILL_EN
  logic             w_cfg_fill;
  logic             r_fill_mode;
`endif

  // Address qualification happens at the top level; only [3:2] matter here.
  assign w_unused_adr = ^{i_wb_adr[31:4] ^ SLV_BASE[31:4], i_wb_adr[1:0]};

  assign w_busy     = (r_state != IDLE);
  assign w_complete = (r_state == WR) & r_cyc & i_wbm_ack & (r_rem == LEN_W'(1));

  rocketcpu_dma_regs #(
    .LEN_W (LEN_W)
  ) u_regs (
    .i_wb_clk   (i_wb_clk),
    .reset      (reset),
    .i_wb_reg   (i_wb_adr[3:2]),
    .i_wb_dat   (i_wb_dat),
    .i_wb_we    (i_wb_we),
    .i_wb_cyc   (i_wb_cyc),
    .o_wb_rdt   (o_wb_rdt),
    .o_wb_ack   (o_wb_ack),
    .i_busy     (w_busy),
    .i_rem      (r_rem),
    .i_complete (w_complete),
    .o_start    (w_start),
    .o_src      (w_cfg_src),
    .o_dst      (w_cfg_dst),
    .o_len      (w_cfg_len),
`ifdef ROCKETCPU_DMA_FILL_EN
    .o_fill     (w_cfg_fill),
`endif
    .o_irq      (o_irq)
  );

  always_ff @(posedge i_wb_clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_buf       <= '0;
      r_rem       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
`ifdef ROCKETCPU_DMA_FILL_EN
      r_fill_mode <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start && (w_cfg_len != '0)) begin
            r_src <= w_cfg_src;
            r_dst <= w_cfg_dst;
            r_rem <= w_cfg_len;
            r_sel <= 4'hF;
            r_cyc <= 1'b1;
`ifdef ROCKETCPU_DMA_FILL_EN
            r_fill_mode <= w_cfg_fill;
            if (w_cfg_fill) begin
              r_buf   <= w_cfg_src;
              r_state <= WR;
              r_we    <= 1'b1;
              r_adr   <= w_cfg_dst;
              r_dat   <= w_cfg_src;
            end else
`endif
            begin
              r_state <= RD;
              r_we    <= 1'b0;
              r_adr   <= w_cfg_src;
            end
          end
        end
        RD: begin
          if (r_cyc && i_wbm_ack) begin
            r_buf   <= i_wbm_rdt;
            r_cyc   <= 1'b0;
            r_state <= WR;
          end
        end
        WR: begin
          // Entered from RD with cyc low: hold it low one cycle, then issue.
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= r_dst;
            r_dat <= r_buf;
          end else if (i_wbm_ack) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_src   <= r_src + 32'd4;
            r_dst   <= r_dst + 32'd4;
            r_rem   <= r_rem - LEN_W'(1);
            r_state <= (r_rem == LEN_W'(1)) ? IDLE : GAP;
          end
        end
        GAP: begin
          r_cyc <= 1'b1;
`ifdef ROCKETCPU_DMA_FILL_EN
          if (r_fill_mode) begin
            r_state <= WR;
            r_we    <= 1'b1;
            r_adr   <= r_dst;
            r_dat   <= r_buf;
          end else
`endif
          begin
            r_state <= RD;
            r_we    <= 1'b0;
            r_adr   <= r_src;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wbm_adr = r_adr;
  assign o_wbm_dat = r_dat;
  assign o_wbm_sel = r_sel;
  assign o_wbm_we  = r_we;
  assign o_wbm_cyc = r_cyc;

endmodule

`default_nettype wire

// File: tb/tb_rocketcpu_wb_dma.sv
// ============================================================================
// Module   : tb_rocketcpu_wb_dma
// Purpose  : Randomised self-checking bench for rocketcpu_wb_dma with a
//            memory/bus model. Fill checks active with ROCKETCPU_DMA_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rocketcpu_wb_dma;

  localparam logic [31:0] A_SRC  = 32'h0600_0000;
  localparam logic [31:0] A_DST  = 32'h0600_0004;
  localparam logic [31:0] A_LEN  = 32'h0600_0008;
  localparam logic [31:0] A_CTRL = 32'h0600_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat, wb_rdt;
  logic        wb_we, wb_cyc, wb_ack;
  logic [31:0] wbm_adr, wbm_dat, wbm_rdt;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_ack;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  rocketcpu_wb_dma u_dut (
    .i_wb_clk  (clk),
    .reset     (rst),
    .i_wb_adr  (wb_adr),
    .i_wb_dat  (wb_dat),
    .i_wb_we   (wb_we),
    .i_wb_cyc  (wb_cyc),
    .o_wb_rdt  (wb_rdt),
    .o_wb_ack  (wb_ack),
    .o_wbm_adr (wbm_adr),
    .o_wbm_dat (wbm_dat),
    .o_wbm_sel (wbm_sel),
    .o_wbm_we  (wbm_we),
    .o_wbm_cyc (wbm_cyc),
    .i_wbm_rdt (wbm_rdt),
    .i_wbm_ack (wbm_ack),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory + bus responder model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$], wr_adr_log[$], wr_dat_log[$];
  int  dly = -1, fix_dly = -1;
  bit  hold_wr = 0, prev_cyc = 0;
  int  n_cyc_start = 0, n_unstable = 0, n_nogap = 0, n_badsel = 0;
  logic [31:0] held_adr, held_dat;
  logic        held_we;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  initial begin
    wbm_ack = 1'b0;
    wbm_rdt = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        wbm_ack = 1'b0; dly = -1; prev_cyc = 0;
      end else if (wbm_ack) begin
        wbm_ack = 1'b0;
        if (wbm_cyc) n_nogap++;
        prev_cyc = wbm_cyc;
      end else if (wbm_cyc) begin
        if (!prev_cyc) begin
          n_cyc_start++;
          held_adr = wbm_adr; held_dat = wbm_dat; held_we = wbm_we;
        end else if (held_adr !== wbm_adr || held_we !== wbm_we || (wbm_we && held_dat !== wbm_dat)) begin
          n_unstable++;
        end
        prev_cyc = 1;
        if (dly < 0) dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 2));
        if (!(hold_wr && wbm_we)) begin
          if (dly == 0) begin
            if (wbm_we) begin
              wr_adr_log.push_back(wbm_adr);
              wr_dat_log.push_back(wbm_dat);
              mem[wbm_adr] = wbm_dat;
              if (wbm_sel != 4'hF) n_badsel++;
            end else begin
              rd_log.push_back(wbm_adr);
              wbm_rdt = mem_rd(wbm_adr);
            end
            wbm_ack = 1'b1;
            dly = -1;
          end else begin
            dly--;
          end
        end
      end else begin
        prev_cyc = 0; dly = -1;
      end
    end
  end

  // ---------------- config slave access ----------------
  task automatic wait_ack(input string tag);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (wb_ack) seen = 1;
    end
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_adr = adr; wb_dat = dat; wb_we = 1'b1; wb_cyc = 1'b1;
    wait_ack("wr_ack_seen");
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1;
    wait_ack("rd_ack_seen");
    dat = wb_rdt;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_ack"}, 32'(wb_ack), 0);
    check_eq({pfx, "_rdt"}, wb_rdt, 0);
    check_eq({pfx, "_cyc"}, 32'(wbm_cyc), 0);
    check_eq({pfx, "_we"},  32'(wbm_we), 0);
    check_eq({pfx, "_adr"}, wbm_adr, 0);
    check_eq({pfx, "_dat"}, wbm_dat, 0);
    check_eq({pfx, "_sel"}, 32'(wbm_sel), 0);
    check_eq({pfx, "_irq"}, 32'(irq), 0);
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_adr_log.delete(); wr_dat_log.delete();
    n_cyc_start = 0; n_unstable = 0; n_nogap = 0; n_badsel = 0;
  endtask

  // Full transfer: expected traffic derived from the word-copy definition.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit ien, input bit fill);
    logic [31:0] ea[$], ed[$], er[$];
    logic [31:0] s_al, d_al, st;
    s_al = {src[31:2], 2'b00};
    d_al = {dst[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      ea.push_back(d_al + 32'(4 * i));
      if (fill) ed.push_back(s_al);
      else begin
        er.push_back(s_al + 32'(4 * i));
        ed.push_back(mem_rd(s_al + 32'(4 * i)));
      end
    end
    clear_logs();
    wb_write(A_SRC, src);
    wb_write(A_DST, dst);
    wb_write(A_LEN, 32'(len));
    wb_write(A_CTRL, (32'(fill) << 3) | (32'(ien) << 1) | 32'h1);
    st = 32'h1;
    for (int p = 0; p < 400 && st[0]; p++) wb_read(A_CTRL, st);
    check_eq("xfer_busy_end", 32'(st[0]), 0);
    check_eq("xfer_done", 32'(st[2]), 1);
    check_eq("xfer_rem_end", 32'(st[31:16]), 0);
    check_eq("xfer_irq", 32'(irq), 32'(ien));
    check_eq("xfer_nwr", 32'(wr_adr_log.size()), 32'(len));
    check_eq("xfer_nrd", 32'(rd_log.size()), 32'(er.size()));
    check_eq("xfer_ncyc", 32'(n_cyc_start), 32'(fill ? len : 2 * len));
    check_eq("xfer_unstable", 32'(n_unstable), 0);
    check_eq("xfer_nogap", 32'(n_nogap), 0);
    check_eq("xfer_sel", 32'(n_badsel), 0);
    for (int i = 0; i < len && i < wr_adr_log.size(); i++) begin
      check_eq("wr_adr", wr_adr_log[i], ea[i]);
      check_eq("wr_dat", wr_dat_log[i], ed[i]);
    end
    for (int i = 0; i < er.size() && i < rd_log.size(); i++) check_eq("rd_adr", rd_log[i], er[i]);
    wb_write(A_CTRL, (32'(ien) << 1) | 32'h4);
    check_eq("clr_irq", 32'(irq), 0);
    wb_read(A_CTRL, st);
    check_eq("clr_done", 32'(st[2]), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, st, src, dst;
    int seq[$];
    int last, len;
    bit found, ien, fill;

    rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // register readback
    wb_write(A_SRC, 32'h0010_0003); wb_read(A_SRC, d); check_eq("src_mask", d, 32'h0010_0000);
    wb_write(A_DST, 32'hFFFF_FFFF); wb_read(A_DST, d); check_eq("dst_mask", d, 32'hFFFF_FFFC);
    wb_write(A_LEN, 32'hABCD_0007); wb_read(A_LEN, d); check_eq("len_rb", d, 32'h0000_0007);
    wb_write(A_CTRL, 32'h8); wb_read(A_CTRL, d);
`ifdef ROCKETCPU_DMA_FILL_EN
    check_eq("ctrl_fill_bit", d, 32'h0000_0008);
`else
    check_eq("ctrl_fill_bit", d, 32'h0000_0000);
`endif
    wb_write(A_CTRL, 32'h0);

    // 4-word copy, slave acks after 2 cycles
    fix_dly = 2;
    run_xfer(32'h0010_0000, 32'h0000_0100, 4, 0, 0);
    fix_dly = -1;
    for (int i = 0; i < 4; i++)
      check_eq("ram_word", mem_rd(32'h100 + 32'(4 * i)), mem_rd(32'h0010_0000 + 32'(4 * i)));

    // irq enabled then disabled
    run_xfer(32'h0010_0040, 32'h0000_0200, 1, 1, 0);
    run_xfer(32'h0010_0044, 32'h0000_0204, 1, 0, 0);

    // zero length: done one cycle after the start ack, no bus traffic
    clear_logs();
    wb_write(A_LEN, 32'h0);
    wb_write(A_CTRL, 32'h3);
    check_eq("zl_irq_ackcyc", 32'(irq), 0);
    @(posedge clk); #1;
    check_eq("zl_irq_next", 32'(irq), 1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("zl_no_cyc", 32'(n_cyc_start), 0);
    wb_write(A_CTRL, 32'h4);

    // busy lockout with rem progression
    fix_dly = 3;
    clear_logs();
    wb_write(A_SRC, 32'h0020_0000);
    wb_write(A_DST, 32'h0000_0300);
    wb_write(A_LEN, 32'd3);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_DST, 32'hDEAD_0000);
    wb_write(A_CTRL, 32'h1);
    st = 32'h1; last = -1;
    for (int p = 0; p < 400 && st[0]; p++) begin
      wb_read(A_CTRL, st);
      if (int'(st[31:16]) != last) begin
        last = int'(st[31:16]);
        if (last != 3) seq.push_back(last);
      end
    end
    fix_dly = -1;
    check_eq("lk_nseq", 32'(seq.size()), 3);
    for (int i = 0; i < 3 && i < seq.size(); i++) check_eq("lk_rem", 32'(seq[i]), 32'(2 - i));
    check_eq("lk_nwr", 32'(wr_adr_log.size()), 3);
    for (int i = 0; i < 3 && i < wr_adr_log.size(); i++)
      check_eq("lk_wr_adr", wr_adr_log[i], 32'h300 + 32'(4 * i));
    wb_read(A_DST, d);
    check_eq("lk_dst_reg", d, 32'h0000_0300);
    wb_write(A_CTRL, 32'h4);

    // reset while a write is pending
    hold_wr = 1;
    wb_write(A_SRC, 32'h0030_0000);
    wb_write(A_DST, 32'h0000_0400);
    wb_write(A_LEN, 32'd2);
    wb_write(A_CTRL, 32'h3);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (wbm_cyc && wbm_we) found = 1;
    end
    check_eq("rst_in_wr", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_cyc_async", 32'(wbm_cyc), 0);
    @(posedge clk); #1;
    check_idle_outputs("rst2");
    @(posedge clk); #1;
    rst = 1'b0; hold_wr = 0;
    wb_read(A_SRC, d);  check_eq("rst_src", d, 0);
    wb_read(A_DST, d);  check_eq("rst_dst", d, 0);
    wb_read(A_LEN, d);  check_eq("rst_len", d, 0);
    wb_read(A_CTRL, d); check_eq("rst_ctrl", d, 0);

    // randomized transfers incl. address wrap
    for (int t = 0; t < 14; t++) begin
      src = (32'h0010_0000 + (32'($urandom_range(0, 1023)) << 2)) | 32'($urandom_range(0, 3));
      dst = 32'h0000_0100 + (32'($urandom_range(0, 1023)) << 2);
      if (t % 5 == 3) src = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (t % 5 == 4) dst = 32'hFFFF_FFF4;
      len  = int'($urandom_range(0, 6));
      ien  = 1'($urandom_range(0, 1));
      fill = 0;
`ifdef ROCKETCPU_DMA_FILL_EN
      fill = ($urandom_range(0, 3) == 0);
`endif
      run_xfer(src, dst, len, ien, fill);
    end

`ifdef ROCKETCPU_DMA_FILL_EN
    run_xfer(32'h1234_5678, 32'h1000_0000, 15, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
